lsu_ctrl: RTL
=============

Name: lsu_ctrl

Overview:
- Load/store sequencer between the CPU execute stage and the word-wide data memory, directly upstream of it.
- The data memory writes whole 32-bit words only and has registered reads: data is valid one clock after the address is presented with write enable low.
- This block:
  - accepts byte, halfword and word loads and stores;
  - performs read-modify-write for sub-word stores;
  - extracts and sign/zero-extends load data;
  - flags misaligned accesses.

Parameters:
- BIG_ENDIAN, 0: byte-lane ordering. 0 = byte k at bits [8k+7:8k]. 1 = byte k at bits [31-8k:24-8k], and the halfword at Addr[1]=0 is bits [31:16].

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- Req  in  1  access request, sampled only in IDLE
- MemOp  in  1  0 = load, 1 = store
- Size  in  2  00 byte, 01 half, 10 word, 11 reserved
- Signed  in  1  load sign-extend (1) / zero-extend (0)
- Addr  in  32  byte address
- StData  in  32  store data, right-justified for sub-word sizes
- Busy  out  1  high in every state except IDLE
- Done  out  1  one-cycle completion pulse
- Misalign  out  1  one-cycle error pulse, coincident with Done
- LdData  out  32  extended load result, held until the next load completes
- DmAd  out  30  word address to data memory (Addr[31:2])
- DmWrData  out  32  write data to data memory
- DmMemWr  out  1  write enable to data memory
- DmRd  in  32  registered read data from data memory

Behaviour:
- Clocking and reset:
  - One clock (Clk); Reset is asynchronous and active-high.
  - Reset forces state IDLE and clears Busy, Done, Misalign, LdData, DmAd, DmWrData and DmMemWr to 0.
  - Reset mid-operation aborts the access; DmMemWr falls immediately and no partial write is issued.
- FSM states: IDLE, READ, CAPT, WRITE, DONE, ERR.
- IDLE:
  - On Req=1, latch MemOp, Size, Signed, Addr, StData; drive DmAd <= Addr[31:2].
  - Misaligned if Size=11, or Size=01 with Addr[0]=1, or Size=10 with Addr[1:0]!=00. Misaligned -> ERR.
  - Aligned word store: DmWrData <= StData -> WRITE.
  - All other aligned requests -> READ.
- READ: DmMemWr=0, DmAd held. Memory captures the read at the end of this cycle -> CAPT.
- CAPT: sample DmRd.
  - Load: select the lane by Addr[1:0] and BIG_ENDIAN, extend per Signed into LdData -> DONE.
  - Sub-word store: DmWrData <= DmRd with only the addressed lane(s) replaced by StData[7:0] or [15:0] -> WRITE.
- WRITE: DmMemWr=1 for exactly one cycle; DmAd and DmWrData stable -> DONE.
- DONE: Done=1 for one cycle -> IDLE.
- ERR: Done=1 and Misalign=1 for one cycle, with no memory access (DmMemWr stays 0) -> IDLE.
- Latency (Req sampled at edge 0; cycle in which Done is high):
  - word store: cycle 2
  - load: cycle 3
  - sub-word store: cycle 4
  - error: cycle 1
- Back-to-back: Req is ignored while Busy=1. A request held high through DONE is accepted on the next IDLE cycle, so Done pulses are never adjacent.
- DmMemWr is high only in WRITE.
- DmAd holds its last value in IDLE.
- LdData is unchanged by stores and errors.

Optional Feature:
- Macro LSU_STAT_EN.
- When defined:
  - adds outputs LdCnt, StCnt, ErrCnt (16 bits each);
  - each increments on the Done of a completed load, a completed store, or an ERR respectively;
  - each saturates at 16'hFFFF;
  - all clear on Reset.
- When undefined, these ports and registers do not exist and the remaining behaviour is identical.

Test Plan:
- Word store Addr=0x10, StData=0xDEADBEEF -> DmMemWr pulses once in cycle 1 with DmAd=0x4 and DmWrData=0xDEADBEEF; Done in cycle 2; no READ cycle.
- Memory word 0x4 = 0x11223344, BIG_ENDIAN=0: byte store Addr=0x12, StData=0xAB -> single write of 0x11AB3344 in cycle 3; Done in cycle 4.
- Same word, signed byte load Addr=0x13 -> LdData=0x00000011. After writing 0x80223344, the same load gives 0xFFFFFF80 and the unsigned load gives 0x00000080.
- BIG_ENDIAN=1, word 0x11223344: unsigned half load Addr=0x12 -> LdData=0x00003344.
- Half load Addr=0x11 -> Done and Misalign in cycle 1; DmMemWr never asserted; LdData unchanged.
- Sub-word store with Reset asserted during CAPT -> outputs 0 immediately, no write occurs, memory word unchanged. With LSU_STAT_EN defined, all counters read 0 afterwards.

Source files
------------

// File: rtl/lsu_ctrl_if.sv
// Bundle of CPU-side request/response and data-memory signals for lsu_ctrl.
// The slave modport is the sequencer's view; master is the CPU/memory side.
interface lsu_ctrl_if;
  logic        Req;
  logic        MemOp;
  logic [1:0]  Size;
  logic        Signed;
  logic [31:0] Addr;
  logic [31:0] StData;
  logic        Busy;
  logic        Done;
  logic        Misalign;
  logic [31:0] LdData;
  logic [29:0] DmAd;
  logic [31:0] DmWrData;
  logic        DmMemWr;
  logic [31:0] DmRd;

  modport slave (
    input  Req, MemOp, Size, Signed, Addr, StData, DmRd,
    output Busy, Done, Misalign, LdData, DmAd, DmWrData, DmMemWr
  );

  modport master (
    output Req, MemOp, Size, Signed, Addr, StData, DmRd,
    input  Busy, Done, Misalign, LdData, DmAd, DmWrData, DmMemWr
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store sequencer in front of a word-wide, registered-read data memory.
// Optional access counters are compiled in when LSU_STAT_EN is defined.
module lsu_ctrl #(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        Clk,
  input  logic        Reset,
  lsu_ctrl_if.slave   bus
`ifdef LSU_STAT_EN
  ,
  output logic [15:0] LdCnt,
  output logic [15:0] StCnt,
  output logic [15:0] ErrCnt
`endif
);

  typedef enum logic [2:0] {IDLE, READ, CAPT, WRITE, DONE, ERR} state_t;

  state_t      state, state_nxt;
  logic        op_q;
  logic        sgn_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic [31:0] st_q;

  logic        misaligned;
  logic        word_store;
  logic [1:0]  byte_lane;
  logic        half_lane;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_ext;
  logic [31:0] merged;

  assign misaligned = (bus.Size == 2'b11) ||
                      (bus.Size == 2'b01 && bus.Addr[0]) ||
                      (bus.Size == 2'b10 && bus.Addr[1:0] != 2'b00);
  assign word_store = bus.MemOp && (bus.Size == 2'b10);

  // Big-endian simply mirrors the lane index within the word.
  assign byte_lane = BIG_ENDIAN ? ~lane_q : lane_q;
  assign half_lane = BIG_ENDIAN ? ~lane_q[1] : lane_q[1];

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    rd_byte = bus.DmRd[8*byte_lane +: 8];
    rd_half = bus.DmRd[16*half_lane +: 16];
    ld_ext  = bus.DmRd;
    merged  = bus.DmRd;
    case (size_q)
      2'b00: begin
        ld_ext = {{24{sgn_q & rd_byte[7]}}, rd_byte};
        merged[8*byte_lane +: 8] = st_q[7:0];
      end
      2'b01: begin
        ld_ext = {{16{sgn_q & rd_half[15]}}, rd_half};
        merged[16*half_lane +: 16] = st_q[15:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.Req) begin
          if (misaligned)      state_nxt = ERR;
          else if (word_store) state_nxt = WRITE;
          else                 state_nxt = READ;
        end
      end
      READ:    state_nxt = CAPT;
      CAPT:    state_nxt = op_q ? WRITE : DONE;
      WRITE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the write strobe is decoded from state, so an async reset drops it at once.
  assign bus.Busy     = (state != IDLE);
  assign bus.Done     = (state == DONE) || (state == ERR);
  assign bus.Misalign = (state == ERR);
  assign bus.DmMemWr  = (state == WRITE);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      // NOTE: sequential state is assigned non-blocking so all registers update together.
      op_q         <= 1'b0;
      sgn_q        <= 1'b0;
      size_q       <= 2'b00;
      lane_q       <= 2'b00;
      st_q         <= '0;
      bus.DmAd     <= '0;
      bus.DmWrData <= '0;
      bus.LdData   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Req) begin
            op_q     <= bus.MemOp;
            sgn_q    <= bus.Signed;
            size_q   <= bus.Size;
            lane_q   <= bus.Addr[1:0];
            st_q     <= bus.StData;
            bus.DmAd <= bus.Addr[31:2];
            if (!misaligned && word_store) bus.DmWrData <= bus.StData;
          end
        end
        CAPT: begin
          if (op_q) bus.DmWrData <= merged;
          else      bus.LdData   <= ld_ext;
        end
        default: ;
      endcase
    end
  end

`ifdef LSU_STAT_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      LdCnt  <= '0;
      StCnt  <= '0;
      ErrCnt <= '0;
    end else begin
      if (state == DONE && !op_q && LdCnt != 16'hFFFF) LdCnt  <= LdCnt + 16'd1;
      if (state == DONE && op_q && StCnt != 16'hFFFF)  StCnt  <= StCnt + 16'd1;
      if (state == ERR && ErrCnt != 16'hFFFF)          ErrCnt <= ErrCnt + 16'd1;
    end
  end
`endif

endmodule
